// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Provides the FSM state type, the minimum ratio, the ratio clamp and the high-phase length.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios 0 and 1 cannot form a clock, so they run as divide-by-2.
    function automatic int unsigned n_eff(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // Posedge high phase. In 50%-duty mode the half-cycle stretch supplies the extra half clk on odd ratios.
    function automatic int unsigned high_len(input int unsigned n, input bit duty50);
        return (duty50 && n[0]) ? (n / 2) : (n - (n / 2));
    endfunction

endpackage

// File: rtl/clk_div_half_dly.sv
// Half-cycle stretch for odd ratios. The negedge copy of the posedge high phase is ORed back in.
// Present only in builds with CLK_DIV_PROG_DUTY50_EN defined.
`ifdef CLK_DIV_PROG_DUTY50_EN
module clk_div_half_dly (
    input  logic clk,
    input  logic rst,
    input  logic hi_i,
    input  logic odd_i,
    output logic clk_o
);

    logic dly_d;
    logic dly_q;

    // Even ratios need no stretch, so the odd flag gates the copy before capture.
    always_comb begin
        dly_d = hi_i & odd_i;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign clk_o = hi_i | dly_q;

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: a single synchronous counter, glitch-free ratio changes and start/stop.
// Define CLK_DIV_PROG_DUTY50_EN for exact 50% duty on odd ratios.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             clk_o,
    output logic             tick,
    output logic             running
);

`ifdef CLK_DIV_PROG_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif
    localparam int unsigned CMP_W = CNT_W + 1;

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] n_act_d, n_act_q;
    logic             hi_d, hi_q;
    logic             tick_d, tick_q;
    logic             running_d, running_q;

    logic [CNT_W-1:0] div_eff_c;
    logic [CMP_W-1:0] cnt_inc_c;
    logic [CMP_W-1:0] high_c;
    logic             terminal_c;

    // One extra bit keeps cnt+1 exact at the largest ratio.
    always_comb begin
        div_eff_c  = CNT_W'(n_eff(32'(div)));
        cnt_inc_c  = CMP_W'(cnt_q) + CMP_W'(1);
        high_c     = CMP_W'(high_len(32'(n_act_q), DUTY50));
        terminal_c = (cnt_inc_c == CMP_W'(n_act_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_act_d = n_act_q;
        hi_d    = hi_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                hi_d  = 1'b0;
                if (en) begin
                    state_d = RUN;
                    n_act_d = div_eff_c;
                    hi_d    = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                // Ratio and stop requests are honoured only at the period boundary.
                if (terminal_c) begin
                    cnt_d = '0;
                    if (en) begin
                        n_act_d = div_eff_c;
                        hi_d    = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        hi_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    hi_d  = (cnt_inc_c < high_c);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hi_d    = 1'b0;
            end
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_act_q   <= CNT_W'(MIN_DIV);
            hi_q      <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_act_q   <= n_act_d;
            hi_q      <= hi_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

`ifdef CLK_DIV_PROG_DUTY50_EN
    clk_div_half_dly u_half_dly (
        .clk   (clk),
        .rst   (rst),
        .hi_i  (hi_q),
        .odd_i (n_act_q[0]),
        .clk_o (clk_o)
    );
`else
    assign clk_o = hi_q;
`endif

    assign tick    = tick_q;
    assign running = running_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; samples 1 time unit after each posedge and after each negedge.
// Expected waveforms are hand-derived bit patterns, first clk of each sequence leftmost.
module tb_clk_div_prog;

    localparam int unsigned CNT_W = 8;
`ifdef CLK_DIV_PROG_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div;
    logic             clk_o;
    logic             tick;
    logic             running;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_prog #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .clk_o   (clk_o),
        .tick    (tick),
        .running (running)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One clk: check registered outputs after the posedge, then clk_o in the middle of the cycle.
    task automatic step(input string tag, input logic e_clk, input logic e_mid,
                        input logic e_tick, input logic e_run);
        @(posedge clk);
        #1;
        chk({tag, ".clk_o"}, clk_o, e_clk);
        chk({tag, ".tick"}, tick, e_tick);
        chk({tag, ".running"}, running, e_run);
        @(negedge clk);
        #1;
        chk({tag, ".clk_o_mid"}, clk_o, e_mid);
    endtask

    task automatic run_seq(input string tag, input int n, input logic [31:0] p_clk,
                           input logic [31:0] p_mid, input logic [31:0] p_tick,
                           input logic [31:0] p_run);
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s[%0d]", tag, i), p_clk[n-1-i], p_mid[n-1-i],
                 p_tick[n-1-i], p_run[n-1-i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        div = 8'd4;
        #1;
        chk("reset.clk_o", clk_o, 1'b0);
        chk("reset.tick", tick, 1'b0);
        chk("reset.running", running, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        run_seq("idle", 2, 32'b00, 32'b00, 32'b00, 32'b00);

        en  = 1'b1;
        div = 8'd4;
        run_seq("div4", 8, 32'b11001100, 32'b11001100, 32'b10001000, 32'hFF);

        div = 8'd5;
        run_seq("div5", 10, 32'b1110011100,
                DUTY50 ? 32'b1100011000 : 32'b1110011100,
                32'b1000010000, 32'h3FF);

        div = 8'd3;
        run_seq("div3", 2, 32'b11, DUTY50 ? 32'b10 : 32'b11, 32'b10, 32'b11);
        div = 8'd7;
        run_seq("div3to7", 8, 32'b01111000,
                DUTY50 ? 32'b01110000 : 32'b01111000,
                32'b01000000, 32'hFF);

        div = 8'd0;
        run_seq("div0", 4, 32'b1010, 32'b1010, 32'b1010, 32'hF);
        div = 8'd1;
        run_seq("div1", 4, 32'b1010, 32'b1010, 32'b1010, 32'hF);

        div = 8'd6;
        run_seq("div6", 2, 32'b11, 32'b11, 32'b10, 32'b11);
        en = 1'b0;
        run_seq("stop", 6, 32'b100000, 32'b100000, 32'b000000, 32'b111100);

        en  = 1'b1;
        div = 8'd8;
        run_seq("restart", 3, 32'b111, 32'b111, 32'b100, 32'b111);

        rst = 1'b1;
        #1;
        chk("rst_async.clk_o", clk_o, 1'b0);
        chk("rst_async.tick", tick, 1'b0);
        chk("rst_async.running", running, 1'b0);
        #1;
        rst = 1'b0;
        run_seq("post_rst", 9, 32'b111100001, 32'b111100001, 32'b100000001, 32'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
